// File: rtl/spi_flash_responder.sv
// SPI Mode 0 serial-flash responder: oversampled SCK/CS/MOSI, decodes READ/PP/WREN/WRDI/RDSR
// and serves them from an internal byte-wide memory that survives reset.
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned PAGE_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_SPI_CLK,
    input  logic i_SPI_MOSI,
    input  logic i_SPI_CS,
    output logic o_SPI_MISO,
    output logic o_MISO_OE,
    output logic o_WEL,
    output logic o_busy,
    output logic o_prog_strobe
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = 5;
    localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'((64'd1 << PAGE_BITS) - 64'd1);

    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_WREN = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_RD_DATA,
        S_PROG_DATA,
        S_STATUS,
        S_IGNORE
    } state_e;

    state_e               state_q;
    logic                 sck_meta_q, sck_sync_q, sck_prev_q;
    logic                 cs_meta_q, cs_sync_q, cs_prev_q;
    logic                 mosi_meta_q, mosi_sync_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [6:0]           rx_q;
    logic [7:0]           tx_q;
    logic [7:0]           cmd_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 extra_q;
    logic                 miso_q, miso_oe_q, wel_q, busy_q, strobe_q;

    logic [7:0]           mem_q [DEPTH];

    logic                 sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c;
    logic [7:0]           rx_byte_c;
    logic [ADDR_BITS-1:0] addr_in_c, rd_addr_c, page_inc_c;
    logic [7:0]           rd_data_c, status_c;
    logic                 mem_we_c;

    // Edge detection on synchronized inputs; a CS rise masks any SCK edge in the same clk
    always_comb begin
        sck_rise_c = sck_sync_q & ~sck_prev_q;
        sck_fall_c = ~sck_sync_q & sck_prev_q;
        cs_rise_c  = cs_sync_q & ~cs_prev_q;
        cs_fall_c  = ~cs_sync_q & cs_prev_q;
        rx_byte_c  = {rx_q, mosi_sync_q};
        addr_in_c  = {addr_q[ADDR_BITS-2:0], mosi_sync_q};
        rd_addr_c  = (state_q == S_ADDR) ? addr_in_c : addr_q + ADDR_BITS'(1);
        rd_data_c  = mem_q[rd_addr_c];
        page_inc_c = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_BITS'(1)) & PAGE_MASK);
        status_c   = {6'b0, wel_q, 1'b0};
        mem_we_c   = (state_q == S_PROG_DATA) && !cs_rise_c && sck_rise_c
                     && (bit_cnt_q == CNT_W'(7));
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[addr_q] <= rx_byte_c;
        end
    end

    // CS flops reset low so a CS already low at reset release never looks like a falling edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            cs_prev_q   <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            extra_q     <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wel_q       <= 1'b0;
            busy_q      <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            sck_meta_q  <= i_SPI_CLK;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            cs_meta_q   <= i_SPI_CS;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= i_SPI_MOSI;
            mosi_sync_q <= mosi_meta_q;
            strobe_q    <= 1'b0;

            if (cs_rise_c) begin
                state_q   <= S_IDLE;
                miso_oe_q <= 1'b0;
                miso_q    <= 1'b0;
                busy_q    <= 1'b0;
                bit_cnt_q <= '0;
                if (state_q == S_IGNORE && !extra_q) begin
                    if (cmd_q == CMD_WREN) begin
                        wel_q <= 1'b1;
                    end else if (cmd_q == CMD_WRDI) begin
                        wel_q <= 1'b0;
                    end
                end
                if (state_q == S_PROG_DATA) begin
                    wel_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (cs_fall_c) begin
                            state_q   <= S_CMD;
                            bit_cnt_q <= '0;
                            rx_q      <= '0;
                            extra_q   <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise_c) begin
                            rx_q      <= rx_byte_c[6:0];
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_W'(7)) begin
                                cmd_q     <= rx_byte_c;
                                bit_cnt_q <= '0;
                                case (rx_byte_c)
                                    CMD_READ, CMD_PP: state_q <= S_ADDR;
                                    CMD_RDSR: begin
                                        state_q   <= S_STATUS;
                                        miso_oe_q <= 1'b1;
                                        tx_q      <= status_c;
                                    end
                                    default: state_q <= S_IGNORE;
                                endcase
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise_c) begin
                            addr_q    <= addr_in_c;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_W'(23)) begin
                                bit_cnt_q <= '0;
                                if (cmd_q == CMD_READ) begin
                                    state_q   <= S_RD_DATA;
                                    miso_oe_q <= 1'b1;
                                    tx_q      <= rd_data_c;
                                end else if (wel_q) begin
                                    state_q <= S_PROG_DATA;
                                end else begin
                                    state_q <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (sck_fall_c) begin
                            miso_q <= tx_q[7];
                            if (bit_cnt_q == CNT_W'(7)) begin
                                bit_cnt_q <= '0;
                                addr_q    <= addr_q + ADDR_BITS'(1);
                                tx_q      <= rd_data_c;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                                tx_q      <= {tx_q[6:0], 1'b0};
                            end
                        end
                    end
                    S_PROG_DATA: begin
                        if (sck_rise_c) begin
                            rx_q <= rx_byte_c[6:0];
                            if (bit_cnt_q == CNT_W'(7)) begin
                                bit_cnt_q <= '0;
                                addr_q    <= page_inc_c;
                                strobe_q  <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    S_STATUS: begin
                        if (sck_fall_c) begin
                            miso_q <= tx_q[7];
                            if (bit_cnt_q == CNT_W'(7)) begin
                                bit_cnt_q <= '0;
                                tx_q      <= status_c;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                                tx_q      <= {tx_q[6:0], 1'b0};
                            end
                        end
                    end
                    S_IGNORE: begin
                        if (sck_rise_c) begin
                            extra_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign o_SPI_MISO    = miso_q;
    assign o_MISO_OE     = miso_oe_q;
    assign o_WEL         = wel_q;
    assign o_busy        = busy_q;
    assign o_prog_strobe = strobe_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SPI master driver plus a MISO byte monitor fed by an expected-byte queue.
module tb_spi_flash_responder;

    localparam int HALF = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic sck   = 1'b0;
    logic mosi  = 1'b0;
    logic cs    = 1'b1;
    logic miso, miso_oe, wel, busy, strobe;

    int pass_cnt   = 0;
    int total_cnt  = 0;
    int strobe_cnt = 0;
    logic oe_seen   = 1'b0;
    logic busy_seen = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_bytes[$];

    logic [7:0] mon_sh   = 8'h00;
    int         mon_bits = 0;

    always #5 clk = ~clk;

    spi_flash_responder #(.ADDR_BITS(12), .PAGE_BITS(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_SPI_CLK     (sck),
        .i_SPI_MOSI    (mosi),
        .i_SPI_CS      (cs),
        .o_SPI_MISO    (miso),
        .o_MISO_OE     (miso_oe),
        .o_WEL         (wel),
        .o_busy        (busy),
        .o_prog_strobe (strobe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        if (strobe) strobe_cnt++;
        if (miso_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    // Monitor: assemble MISO bytes at master sampling edges while the drive enable is up
    always @(posedge sck or negedge cs) begin
        if (!sck) begin
            mon_bits = 0;
        end else if (!cs && miso_oe) begin
            mon_sh = {mon_sh[6:0], miso};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL miso_byte: got 0x%0h expected no byte", mon_sh);
                end else begin
                    chk("miso_byte", 32'(mon_sh), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic spi_xfer(input int nbits);
        @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] b;
            b = (i / 8 < tx_bytes.size()) ? tx_bytes[i / 8] : 8'h00;
            mosi = b[7 - (i % 8)];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic load_cmd(input logic [7:0] c, input logic [23:0] a, input bit with_addr);
        tx_bytes.delete();
        tx_bytes.push_back(c);
        if (with_addr) begin
            tx_bytes.push_back(a[23:16]);
            tx_bytes.push_back(a[15:8]);
            tx_bytes.push_back(a[7:0]);
        end
    endtask

    task automatic wren();
        load_cmd(8'h06, 24'h0, 1'b0);
        spi_xfer(8);
        chk("wel_after_wren", 32'(wel), 32'd1);
    endtask

    task automatic prog(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1,
                        input int nd, input int exp_str, input logic exp_wel);
        int s0;
        load_cmd(8'h02, a, 1'b1);
        tx_bytes.push_back(d0);
        tx_bytes.push_back(d1);
        s0 = strobe_cnt;
        spi_xfer(32 + 8 * nd);
        chk("prog_strobes", 32'(strobe_cnt - s0), 32'(exp_str));
        chk("wel_after_prog", 32'(wel), 32'(exp_wel));
    endtask

    task automatic rd(input logic [23:0] a, input int n, input logic [7:0] e0, input logic [7:0] e1);
        exp_q.push_back(e0);
        if (n == 2) exp_q.push_back(e1);
        load_cmd(8'h03, a, 1'b1);
        spi_xfer(32 + 8 * n);
    endtask

    initial begin
        int s0;
        // Reset asserted with CS low and SCK toggling
        repeat (4) @(negedge clk);
        cs = 1'b0;
        repeat (6) begin
            repeat (2) @(negedge clk);
            sck = ~sck;
        end
        s0 = strobe_cnt;
        chk("rst_oe", 32'(miso_oe), 32'd0);
        chk("rst_wel", 32'(wel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        // Release with CS already low: must stay idle
        reset = 1'b1;
        mosi  = 1'b1;
        repeat (32) begin
            repeat (HALF) @(negedge clk);
            sck = ~sck;
        end
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_oe", 32'(miso_oe), 32'd0);
        chk("rel_strobes", 32'(strobe_cnt - s0), 32'd0);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);

        // Seed, then program without enable leaves contents intact
        wren();
        prog(24'h000123, 8'h3C, 8'h00, 1, 1, 1'b0);
        prog(24'h000123, 8'h5A, 8'h00, 1, 0, 1'b0);
        rd(24'h000123, 1, 8'h3C, 8'h00);

        // Program with enable
        wren();
        prog(24'h000123, 8'hA5, 8'h00, 1, 1, 1'b0);
        rd(24'h000123, 1, 8'hA5, 8'h00);

        // Page wrap
        wren();
        prog(24'h000200, 8'h77, 8'h00, 1, 1, 1'b0);
        wren();
        prog(24'h0001FF, 8'h11, 8'h22, 2, 2, 1'b0);
        rd(24'h0001FF, 1, 8'h11, 8'h00);
        rd(24'h000100, 1, 8'h22, 8'h00);
        rd(24'h000200, 1, 8'h77, 8'h00);

        // Continuous read across the top of memory, through an aliased address
        wren();
        prog(24'h000FFF, 8'hC1, 8'h00, 1, 1, 1'b0);
        wren();
        prog(24'h000000, 8'hC2, 8'h00, 1, 1, 1'b0);
        rd(24'h00AFFF, 2, 8'hC1, 8'hC2);

        // Status register
        wren();
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        load_cmd(8'h05, 24'h0, 1'b0);
        spi_xfer(24);
        chk("wel_after_rdsr", 32'(wel), 32'd1);
        load_cmd(8'h04, 24'h0, 1'b0);
        spi_xfer(8);
        chk("wel_after_wrdi", 32'(wel), 32'd0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        load_cmd(8'h05, 24'h0, 1'b0);
        spi_xfer(24);

        // Abort mid data byte
        wren();
        prog(24'h000010, 8'h66, 8'h00, 1, 1, 1'b0);
        wren();
        load_cmd(8'h02, 24'h000010, 1'b1);
        tx_bytes.push_back(8'hFF);
        s0 = strobe_cnt;
        spi_xfer(37);
        chk("abort_strobes", 32'(strobe_cnt - s0), 32'd0);
        chk("abort_wel", 32'(wel), 32'd0);
        rd(24'h000010, 1, 8'h66, 8'h00);

        // Unknown command never drives MISO
        load_cmd(8'hAB, 24'h0, 1'b0);
        @(negedge clk);
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        spi_xfer(24);
        chk("unknown_oe", 32'(oe_seen), 32'd0);
        chk("unknown_busy", 32'(busy_seen), 32'd1);

        // WREN with an extra bit does nothing; PP with zero data bytes still clears WEL
        load_cmd(8'h06, 24'h0, 1'b0);
        spi_xfer(9);
        chk("wren_extra_wel", 32'(wel), 32'd0);
        wren();
        prog(24'h000300, 8'h00, 8'h00, 0, 0, 1'b0);
        wren();
        load_cmd(8'h04, 24'h0, 1'b0);
        spi_xfer(9);
        chk("wrdi_extra_wel", 32'(wel), 32'd1);

        // Reset in the middle of a transaction
        s0 = strobe_cnt;
        @(negedge clk);
        cs = 1'b0;
        repeat (8) begin
            repeat (HALF) @(negedge clk);
            sck = ~sck;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_wel", 32'(wel), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (16) begin
            repeat (HALF) @(negedge clk);
            sck = ~sck;
        end
        chk("midrst_rel_busy", 32'(busy), 32'd0);
        chk("midrst_rel_oe", 32'(miso_oe), 32'd0);
        chk("midrst_strobes", 32'(strobe_cnt - s0), 32'd0);
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        rd(24'h000123, 1, 8'hA5, 8'h00);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
